// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - op encodings, op-class helpers and sequencer state type for the MDU
package mdu_pkg;

  localparam logic [3:0] MDU_MULT  = 4'd0;
  localparam logic [3:0] MDU_MULTU = 4'd1;
  localparam logic [3:0] MDU_DIV   = 4'd2;
  localparam logic [3:0] MDU_DIVU  = 4'd3;
  localparam logic [3:0] MDU_MTHI  = 4'd4;
  localparam logic [3:0] MDU_MTLO  = 4'd5;
  localparam logic [3:0] MDU_MADD  = 4'd6;
  localparam logic [3:0] MDU_MADDU = 4'd7;
  localparam logic [3:0] MDU_MSUB  = 4'd8;
  localparam logic [3:0] MDU_MSUBU = 4'd9;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_mul(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_MADD) ||
           (op == MDU_MADDU) || (op == MDU_MSUB) || (op == MDU_MSUBU);
  endfunction

  function automatic logic is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_move(input logic [3:0] op);
    return (op == MDU_MTHI) || (op == MDU_MTLO);
  endfunction

endpackage

// File: rtl/mdu_if.sv
// rtl/mdu_if.sv - EX-stage request/result bundle between controller and MDU (cancel only with MDU_CANCEL_EN)
interface mdu_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] d1;
  logic [WIDTH-1:0] d2;
`ifdef MDU_CANCEL_EN
  logic             cancel;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

`ifdef MDU_CANCEL_EN
  modport master (output start, op, d1, d2, cancel, input busy, done, hi, lo);
  modport slave  (input start, op, d1, d2, cancel, output busy, done, hi, lo);
`else
  modport master (output start, op, d1, d2, input busy, done, hi, lo);
  modport slave  (input start, op, d1, d2, output busy, done, hi, lo);
`endif

endinterface

// File: rtl/mdu_calc.sv
// rtl/mdu_calc.sv - combinational next-{hi,lo} datapath for multiply, multiply-accumulate and divide
module mdu_calc
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt,
  output logic             we
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic                   mul_signed;
  logic [2*WIDTH-1:0]     ext1, ext2, prod, acc, res;
  logic                   div_zero, div_ovf;
  logic [WIDTH-1:0]       divisor;
  logic signed [WIDTH-1:0] sd1, sd2, sq, sr;
  logic [WIDTH-1:0]       uq, ur;

  // One shared 2W multiplier (operands extended per signedness) plus divider; the
  // overflow case divides by +1 instead, which yields quotient=d1 and remainder=0.
  always_comb begin
    mul_signed = (op == MDU_MULT) || (op == MDU_MADD) || (op == MDU_MSUB);
    ext1 = mul_signed ? {{WIDTH{d1[WIDTH-1]}}, d1} : {{WIDTH{1'b0}}, d1};
    ext2 = mul_signed ? {{WIDTH{d2[WIDTH-1]}}, d2} : {{WIDTH{1'b0}}, d2};
    prod = ext1 * ext2;
    acc  = {hi, lo};

    div_zero = (d2 == '0);
    div_ovf  = (d1 == MIN_NEG) && (d2 == '1);
    divisor  = div_zero ? WIDTH'(1) : d2;
    sd1      = $signed(d1);
    sd2      = div_ovf ? $signed(WIDTH'(1)) : $signed(divisor);
    sq       = sd1 / sd2;
    sr       = sd1 % sd2;
    uq       = d1 / divisor;
    ur       = d1 % divisor;

    res = acc;
    case (op)
      MDU_MULT, MDU_MULTU: res = prod;
      MDU_MADD, MDU_MADDU: res = acc + prod;
      MDU_MSUB, MDU_MSUBU: res = acc - prod;
      MDU_DIV:             res = {sr, sq};
      MDU_DIVU:            res = {ur, uq};
      default:             res = acc;
    endcase

    we     = is_mul(op) || (is_div(op) && !div_zero);
    hi_nxt = res[2*WIDTH-1:WIDTH];
    lo_nxt = res[WIDTH-1:0];
  end

endmodule

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multiply/divide unit with HI/LO, fixed latency busy and done pulse; optional MDU_CANCEL_EN
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input logic clk,
  input logic reset,
  mdu_if.slave bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  mdu_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             busy_q, done_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic [WIDTH-1:0] hi_nxt, lo_nxt;
  logic             calc_we;
  logic             cancel_req;

`ifdef MDU_CANCEL_EN
  assign cancel_req = bus.cancel;
`else
  assign cancel_req = 1'b0;
`endif

  mdu_calc #(.WIDTH(WIDTH)) u_calc (
    .op     (op_q),
    .d1     (a_q),
    .d2     (b_q),
    .hi     (hi_q),
    .lo     (lo_q),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt),
    .we     (calc_we)
  );

  // Sequencer: accept/latch in idle, count down while running, commit HI/LO on the last edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      op_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start && !cancel_req) begin
            if (is_mul(bus.op) || is_div(bus.op)) begin
              op_q   <= bus.op;
              a_q    <= bus.d1;
              b_q    <= bus.d2;
              cnt    <= is_div(bus.op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
              busy_q <= 1'b1;
              state  <= ST_RUN;
            end else if (bus.op == MDU_MTHI) begin
              hi_q <= bus.d1;
            end else if (bus.op == MDU_MTLO) begin
              lo_q <= bus.d1;
            end
          end
        end
        ST_RUN: begin
          if (cancel_req) begin
            cnt    <= '0;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end else if (cnt == CNT_W'(1)) begin
            if (calc_we) begin
              hi_q <= hi_nxt;
              lo_q <= lo_nxt;
            end
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - scoreboard bench for mdu_unit: directed cases plus randomized ops vs arithmetic model
module tb_mdu_unit;
  import mdu_pkg::*;

  localparam int W  = 32;
  localparam int ML = 5;
  localparam int DL = 10;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if #(.WIDTH(W)) bus();

  mdu_unit #(.WIDTH(W), .MUL_LAT(ML), .DIV_LAT(DL)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t         sb[$];
  exp_t         cur;
  int           checks = 0;
  int           errors = 0;
  int           busy_run = 0;
  logic [W-1:0] mhi = '0;
  logic [W-1:0] mlo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: architectural {hi,lo} after an op, from plain 64-bit integer arithmetic.
  function automatic logic [63:0] ref_model(input logic [3:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [63:0] acc);
    logic [63:0] p;
    longint      x, y, q, r;
    if (op == 4'd0 || op == 4'd6 || op == 4'd8)
      p = 64'(longint'($signed(a)) * longint'($signed(b)));
    else
      p = {32'h0, a} * {32'h0, b};
    case (op)
      4'd0, 4'd1: return p;
      4'd6, 4'd7: return acc + p;
      4'd8, 4'd9: return acc - p;
      4'd2, 4'd3: begin
        if (b == '0) return acc;
        x = (op == 4'd2) ? longint'($signed(a)) : longint'({32'h0, a});
        y = (op == 4'd2) ? longint'($signed(b)) : longint'({32'h0, b});
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
      end
      default: return acc;
    endcase
  endfunction

  // Monitor: every done pulse pops one expectation and checks HI/LO and the busy run length.
  always @(negedge clk) begin
    if (reset) begin
      busy_run = 0;
    end else begin
      if (bus.busy) busy_run++;
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending op");
        end else begin
          cur = sb.pop_front();
          check("done_hi", 64'(bus.hi), 64'(cur.hi));
          check("done_lo", 64'(bus.lo), 64'(cur.lo));
          check("busy_len", 64'(busy_run), 64'(cur.lat));
        end
      end
      if (!bus.busy) busy_run = 0;
    end
  end

  // Drive one op at the current negedge (unit assumed idle) and record the expectation.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] nx;
    exp_t        e;
    bus.start = 1'b1;
    bus.op    = op;
    bus.d1    = a;
    bus.d2    = b;
    if (op <= 4'd3 || (op >= 4'd6 && op <= 4'd9)) begin
      nx    = ref_model(op, a, b, {mhi, mlo});
      e.hi  = nx[63:32];
      e.lo  = nx[31:0];
      e.lat = (op == 4'd2 || op == 4'd3) ? DL : ML;
      sb.push_back(e);
      mhi = e.hi;
      mlo = e.lo;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_set", 64'(bus.busy), 64'd1);
    end else begin
      if (op == 4'd4) mhi = a;
      if (op == 4'd5) mlo = a;
      @(negedge clk);
      bus.start = 1'b0;
      check("move_busy", 64'(bus.busy), 64'd0);
      check("move_hilo", {bus.hi, bus.lo}, {mhi, mlo});
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      checks++;
      errors++;
      $display("FAIL busy_timeout: got busy=1 expected 0 within 200 cycles");
    end
  endtask

  task automatic run(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(op, a, b);
    wait_idle();
    check("arch_hilo", {bus.hi, bus.lo}, {mhi, mlo});
  endtask

  function automatic logic [W-1:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    logic [3:0] rop;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.d1    = '0;
    bus.d2    = '0;
`ifdef MDU_CANCEL_EN
    bus.cancel = 1'b0;
`endif
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("reset_busy_done", {62'd0, bus.busy, bus.done}, 64'd0);

    run(MDU_MULT, -32'sd3, 32'd5);
    check("mult_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    run(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
    check("multu_max", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFE);
    run(MDU_MADD, 32'd1, 32'd2);
    check("madd_carry", {bus.hi, bus.lo}, 64'h0000_0002_0000_0000);
    run(MDU_DIV, -32'sd7, 32'd2);
    check("div_neg", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    run(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
    issue(MDU_MTHI, 32'h55, 32'd0);
    issue(MDU_MTLO, 32'h55, 32'd0);
    run(MDU_DIVU, 32'd9, 32'd0);
    check("divu_zero", {bus.hi, bus.lo}, 64'h0000_0055_0000_0055);
    run(MDU_MSUB, 32'd3, 32'd4);

    // Back-to-back: accept on the first cycle busy is low again.
    issue(MDU_MULTU, 32'd7, 32'd6);
    wait_idle();
    run(MDU_MSUBU, 32'd2, 32'd3);

    // Start while busy must be ignored; only the divide commits.
    issue(MDU_DIV, 32'd100, 32'd7);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MDU_MULT;
    bus.d1    = 32'd3;
    bus.d2    = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();
    check("ignore_busy_start", {bus.hi, bus.lo}, {mhi, mlo});

    // Undefined ops are ignored.
    issue(4'd12, 32'h1234, 32'h5678);
    issue(4'd15, 32'hDEAD, 32'hBEEF);

    // Reset in the middle of a multiply clears everything.
    issue(MDU_MULT, 32'd11, 32'd13);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    mhi = '0;
    mlo = '0;
    @(negedge clk);
    reset = 1'b0;
    check("midop_reset_hilo", {bus.hi, bus.lo}, 64'd0);
    check("midop_reset_busy", 64'(bus.busy), 64'd0);
    repeat (8) @(negedge clk);

`ifdef MDU_CANCEL_EN
    issue(MDU_MTHI, 32'hA5A5, 32'd0);
    issue(MDU_MTLO, 32'h5A5A, 32'd0);
    bus.start = 1'b1;
    bus.op    = MDU_MULT;
    bus.d1    = 32'd9;
    bus.d2    = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_busy", 64'(bus.busy), 64'd0);
    check("cancel_hilo", {bus.hi, bus.lo}, {mhi, mlo});
    repeat (8) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = MDU_MADD;
    bus.d1    = 32'd5;
    bus.d2    = 32'd5;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_final_busy", 64'(bus.busy), 64'd0);
    check("cancel_final_hilo", {bus.hi, bus.lo}, {mhi, mlo});
    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    bus.op     = MDU_MTHI;
    bus.d1     = 32'h7777;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    check("cancel_idle_move", {bus.hi, bus.lo}, {mhi, mlo});
    repeat (4) @(negedge clk);
`endif

    for (int i = 0; i < 40; i++) begin
      rop = ($urandom_range(0, 9) == 0) ? 4'd13 : 4'($urandom_range(0, 9));
      if (rop == MDU_MTHI || rop == MDU_MTLO || rop > 4'd9)
        issue(rop, rnd_val(), rnd_val());
      else
        run(rop, rnd_val(), rnd_val());
    end

    repeat (4) @(negedge clk);
    check("scoreboard_drain", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
